// File: rtl/jk_drive_seq_if.sv
// Command handshake bundle for jk_drive_seq: valid/ready plus the {j,k} opcode
// and the per-command hold count.
interface jk_drive_seq_if #(
    parameter int HOLD_W = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [HOLD_W-1:0] cmd_hold;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_hold,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_hold,
        output cmd_ready
    );
endinterface

// File: rtl/jk_drive_seq.sv
// Queued JK-latch drive sequencer: FIFO of {op,hold} commands, each driven for
// max(hold,1) cycles then a one-cycle gap. Define JK_DRIVE_SEQ_CHECK_EN to add the q_fb check.
module jk_drive_seq #(
    parameter int DEPTH  = 4,
    parameter int HOLD_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    jk_drive_seq_if.slave          cmd,
    output logic                   j,
    output logic                   k,
    output logic                   busy,
    output logic                   exp_q,
    input  logic                   q_fb,
    output logic                   err,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [1:0]          state;
    logic [HOLD_W+1:0]   mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                push;
    logic                pop;
    logic [1:0]          head_op;
    logic [HOLD_W-1:0]   head_hold;
    logic [1:0]          op_r;
    logic [HOLD_W-1:0]   cnt;

    // Ready depends only on the registered level, so a same-edge pop never frees a full FIFO.
    assign cmd.cmd_ready = (level < FULL_LVL);
    assign push          = cmd.cmd_valid && cmd.cmd_ready;
    assign pop           = (state != DRIVE) && (level != '0);
    assign {head_op, head_hold} = mem[rd_ptr];
    assign busy          = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wr_ptr] <= {cmd.cmd_op, cmd.cmd_hold};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            state  <= IDLE;
            j      <= 1'b0;
            k      <= 1'b0;
            exp_q  <= 1'b0;
            op_r   <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase

            case (state)
                IDLE, GAP: begin
                    if (pop) begin
                        state  <= DRIVE;
                        j      <= head_op[1];
                        k      <= head_op[0];
                        op_r   <= head_op;
                        cnt    <= (head_hold == '0) ? HOLD_W'(1) : head_hold;
                    end else begin
                        state  <= IDLE;
                        j      <= 1'b0;
                        k      <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (cnt == HOLD_W'(1)) begin
                        state <= GAP;
                        j     <= 1'b0;
                        k     <= 1'b0;
                        case (op_r)
                            2'b01:   exp_q <= 1'b0;
                            2'b10:   exp_q <= 1'b1;
                            2'b11:   exp_q <= ~exp_q;
                            default: exp_q <= exp_q;
                        endcase
                    end else begin
                        cnt <= cnt - HOLD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    j     <= 1'b0;
                    k     <= 1'b0;
                end
            endcase
        end
    end

`ifdef JK_DRIVE_SEQ_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (state == GAP && q_fb != exp_q) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_q_fb;
    assign unused_q_fb = q_fb;
    assign err         = 1'b0;
`endif
endmodule

// File: tb/tb_jk_drive_seq.sv
// Scoreboard bench for jk_drive_seq: stimulus pushes hand-computed expectations,
// a monitor pops one entry per observed drive segment.
module tb_jk_drive_seq;
    localparam int DEPTH  = 4;
    localparam int HOLD_W = 4;
`ifdef JK_DRIVE_SEQ_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       j, k, busy, exp_q, q_fb, err;
    logic [2:0] level;
    logic       qm = 1'b0;
    logic       prev11 = 1'b0;
    logic       force0 = 1'b0;

    typedef struct {
        logic [1:0] op;
        int         cyc;
        logic       eq;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   w;

    jk_drive_seq_if #(.HOLD_W(HOLD_W)) cif ();

    jk_drive_seq #(.DEPTH(DEPTH), .HOLD_W(HOLD_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .cmd   (cif),
        .j     (j),
        .k     (k),
        .busy  (busy),
        .exp_q (exp_q),
        .q_fb  (q_fb),
        .err   (err),
        .level (level)
    );

    always #5 clk = ~clk;

    // Behavioural JK latch; a held 11 toggles only once.
    always @(posedge clk) begin
        if (!rst) begin
            qm     <= 1'b0;
            prev11 <= 1'b0;
        end else begin
            case ({j, k})
                2'b10:   qm <= 1'b1;
                2'b01:   qm <= 1'b0;
                2'b11:   if (!prev11) qm <= ~qm;
                default: ;
            endcase
            prev11 <= j & k;
        end
    end
    assign q_fb = force0 ? 1'b0 : qm;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop();
        @(negedge clk);
        cif.cmd_valid = 1'b0;
    endtask

    task automatic push(input logic [1:0] op, input logic [HOLD_W-1:0] hold, input int cyc,
                        input logic eq, input bit enq, output int waits);
        logic r;
        exp_t e;
        waits = 0;
        @(negedge clk);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_hold  = hold;
        r = cif.cmd_ready;
        while (!r && waits < 50) begin
            @(negedge clk);
            waits++;
            r = cif.cmd_ready;
        end
        if (!r) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got ready=0 want ready=1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        if (r && enq) begin
            e.op  = op;
            e.cyc = cyc;
            e.eq  = eq;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || level != 3'd0) && n < 200) begin
            tick();
            n++;
        end
        chk("idle_reached", 32'(n < 200), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        sb.delete();
        rst           = 1'b0;
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = 2'b10;
        cif.cmd_hold  = 4'd1;
        tick();
        tick();
        chk("rst_level", level, 3'd0);
        chk("rst_jk", {j, k}, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_exp_q", exp_q, 1'b0);
        chk("rst_err", err, 1'b0);
        @(negedge clk);
        rst           = 1'b1;
        cif.cmd_valid = 1'b0;
        tick();
        chk("rst_ready", cif.cmd_ready, 1'b1);
        chk("rst_no_push", level, 3'd0);
    endtask

    // Monitor: a segment is a run of identical nonzero {j,k}; it must end in a gap.
    initial begin : monitor
        logic [1:0] seg_op;
        int         seg_cnt;
        bit         in_seg;
        exp_t       e;
        seg_op  = 2'b00;
        seg_cnt = 0;
        in_seg  = 1'b0;
        forever begin
            tick();
            if (!rst) begin
                in_seg = 1'b0;
            end else if (in_seg && {j, k} == seg_op) begin
                seg_cnt++;
            end else begin
                if (in_seg) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_cmd: got op=%0b want no command", seg_op);
                    end else begin
                        e = sb.pop_front();
                        chk("cmd_op", 32'(seg_op), 32'(e.op));
                        chk("cmd_cycles", seg_cnt, e.cyc);
                        chk("gap_jk", {j, k}, 2'b00);
                        chk("gap_busy", busy, 1'b1);
                        chk("cmd_exp_q", exp_q, e.eq);
                    end
                    in_seg = 1'b0;
                end
                if ({j, k} != 2'b00) begin
                    in_seg  = 1'b1;
                    seg_op  = {j, k};
                    seg_cnt = 1;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL global_timeout: got no finish want finish before 200000");
        $fatal(1);
    end

    initial begin : stim
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 2'b00;
        cif.cmd_hold  = '0;

        do_reset();

        // Single set, hold 3.
        push(2'b10, 4'd3, 3, 1'b1, 1'b1, w);
        chk("set_not_early", j, 1'b0);
        drop();
        tick(); chk("set_c1", {j, k}, 2'b10);
        tick(); chk("set_c2", {j, k}, 2'b10);
        tick(); chk("set_c3", {j, k}, 2'b10);
        tick(); chk("set_gap_jk", {j, k}, 2'b00);
        chk("set_gap_busy", busy, 1'b1);
        tick(); chk("set_idle", busy, 1'b0);
        chk("set_exp_q", exp_q, 1'b1);

        // Fill while a long clear is being driven.
        push(2'b01, 4'd8, 8, 1'b0, 1'b1, w);
        drop();
        tick();
        tick();
        push(2'b10, 4'd2, 2, 1'b1, 1'b1, w);
        push(2'b11, 4'd1, 1, 1'b0, 1'b1, w);
        push(2'b01, 4'd1, 1, 1'b0, 1'b1, w);
        push(2'b10, 4'd3, 3, 1'b1, 1'b1, w);
        chk("fill_level", level, 3'd4);
        chk("fill_ready_low", cif.cmd_ready, 1'b0);
        push(2'b11, 4'd0, 1, 1'b0, 1'b1, w);
        chk("fill_held_off", 32'(w > 0), 32'd1);
        drop();
        wait_idle();
        chk("fill_exp_q", exp_q, 1'b0);

        // Two toggles with hold 0.
        push(2'b11, 4'd0, 1, 1'b1, 1'b1, w);
        push(2'b11, 4'd0, 1, 1'b0, 1'b1, w);
        drop();
        wait_idle();
        chk("tog_exp_q", exp_q, 1'b0);

        // Feedback check with q_fb stuck low.
        force0 = 1'b1;
        push(2'b10, 4'd1, 1, 1'b1, 1'b1, w);
        drop();
        wait_idle();
        tick();
        chk("chk_err", err, ERR_EXP);
        repeat (4) tick();
        chk("chk_err_sticky", err, ERR_EXP);
        force0 = 1'b0;
        do_reset();

        // Reset during the second drive cycle.
        push(2'b10, 4'd1, 1, 1'b1, 1'b1, w);
        drop();
        wait_idle();
        chk("pre_abort_exp_q", exp_q, 1'b1);
        push(2'b10, 4'd5, 5, 1'b1, 1'b0, w);
        drop();
        tick();
        tick();
        chk("abort_driving", {j, k}, 2'b10);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("abort_jk", {j, k}, 2'b00);
        chk("abort_exp_q", exp_q, 1'b0);
        chk("abort_level", level, 3'd0);
        chk("abort_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("abort_idle", busy, 1'b0);
        chk("abort_ready", cif.cmd_ready, 1'b1);

        repeat (3) tick();
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
